// File: rtl/keccak_pkg.sv
// Shared Keccak framing definitions: lane geometry, feed FSM states and the
// SHA-3 pad10*1 constants used by the permutation input feeder.
package keccak_pkg;

  localparam int LANES  = 25;
  localparam int LANE_W = 64;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABSORB = 3'd1,
    CAP    = 3'd2,
    CAP2   = 3'd3,
    PAD    = 3'd4,
    ZERO   = 3'd5,
    CAPEND = 3'd6
  } feed_st_t;

  localparam logic [7:0] DOMAIN_SHA3 = 8'h06;
  localparam lane_t      PAD_END     = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/perm_feed_pad_lane.sv
// Combinational lane padder: keeps the valid low bytes of a final word, drops the
// domain byte right after them and sets the closing pad bit on the last rate lane.
module pad_lane
  import keccak_pkg::*;
#(
  parameter logic [7:0] DOMAIN = DOMAIN_SHA3
) (
  input  lane_t       din,
  input  logic [3:0]  nbytes,
  input  logic        is_last,
  input  logic        is_rate_end,
  output lane_t       padded_o
);

  logic [3:0] n;

  // NOTE: every output of this block gets a default before any branch so no latch is inferred.
  always_comb begin
    n        = (nbytes > 4'd8) ? 4'd8 : nbytes;
    padded_o = din;
    // A full final word passes unchanged; its padding goes into a following lane.
    if (is_last && (n != 4'd8)) begin
      for (int b = 0; b < 8; b++) begin
        if (4'(b) < n) begin
          padded_o[8*b +: 8] = din[8*b +: 8];
        end else if (4'(b) == n) begin
          padded_o[8*b +: 8] = DOMAIN;
        end else begin
          padded_o[8*b +: 8] = 8'h00;
        end
      end
      if (is_rate_end) begin
        padded_o = padded_o | PAD_END;
      end
    end
  end

endmodule

// File: rtl/perm_feed.sv
// Frames an unframed 64-bit message stream into 25-lane Keccak input frames with
// SHA-3 pad10*1 padding; lanes RATE..24 of every frame are zero.
module perm_feed
  import keccak_pkg::*;
#(
  parameter int         RATE   = 17,
  parameter logic [7:0] DOMAIN = DOMAIN_SHA3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  output logic        stopin,
  input  logic        lastin,
  input  logic [3:0]  nbytes,
  input  logic [63:0] din,
  output logic        pushout,
  input  logic        stopout,
  output logic        firstout,
  output logic [63:0] dout
);

  localparam logic [4:0] RATE_END  = 5'(RATE - 1);
  localparam logic [4:0] LAST_LANE = 5'(LANES - 1);

  feed_st_t   state_q, state_d;
  logic [4:0] lane_q, lane_d;
  logic       pushout_q, pushout_d;
  logic       firstout_q, firstout_d;
  lane_t      dout_q, dout_d;

  logic       load_en, accept, at_rate_end, at_last_lane, full_word, emit;
  lane_t      lane_val, pad_din, padded;
  logic [3:0] pad_nbytes;
  logic       pad_last;

  assign at_rate_end  = (lane_q == RATE_END);
  assign at_last_lane = (lane_q == LAST_LANE);
  assign full_word    = (nbytes >= 4'd8);

  // Output register refills when empty or when its lane leaves this cycle.
  assign load_en = !pushout_q || !stopout;
  assign stopin  = ((state_q != IDLE) && (state_q != ABSORB)) || (pushout_q && stopout);
  assign accept  = pushin && !stopin;

  // A standalone pad lane is an empty final word pushed through the same padder.
  always_comb begin
    pad_din    = din;
    pad_nbytes = nbytes;
    pad_last   = lastin;
    if (state_q == PAD) begin
      pad_din    = '0;
      pad_nbytes = 4'd0;
      pad_last   = 1'b1;
    end
  end

  pad_lane #(
    .DOMAIN (DOMAIN)
  ) u_pad (
    .din         (pad_din),
    .nbytes      (pad_nbytes),
    .is_last     (pad_last),
    .is_rate_end (at_rate_end),
    .padded_o    (padded)
  );

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    pushout_d  = pushout_q;
    firstout_d = firstout_q;
    dout_d     = dout_q;
    emit       = 1'b0;
    lane_val   = '0;
    case (state_q)
      IDLE, ABSORB: begin
        if (load_en) begin
          pushout_d = 1'b0;
          if (accept) begin
            emit     = 1'b1;
            lane_val = padded;
            if (!lastin) begin
              state_d = at_rate_end ? CAP : ABSORB;
            end else if (!full_word) begin
              state_d = at_rate_end ? CAPEND : ZERO;
            end else begin
              state_d = at_rate_end ? CAP2 : PAD;
            end
          end
        end
      end
      CAP: begin
        emit = load_en;
        if (load_en && at_last_lane) state_d = ABSORB;
      end
      CAP2: begin
        emit = load_en;
        if (load_en && at_last_lane) state_d = PAD;
      end
      PAD: begin
        emit     = load_en;
        lane_val = padded;
        if (load_en) state_d = at_rate_end ? CAPEND : ZERO;
      end
      ZERO: begin
        emit     = load_en;
        lane_val = at_rate_end ? PAD_END : '0;
        if (load_en && at_rate_end) state_d = CAPEND;
      end
      CAPEND: begin
        emit = load_en;
        if (load_en && at_last_lane) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      pushout_d  = 1'b1;
      firstout_d = (lane_q == 5'd0);
      dout_d     = lane_val;
      lane_d     = at_last_lane ? 5'd0 : lane_q + 5'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= 5'd0;
      pushout_q  <= 1'b0;
      firstout_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      pushout_q  <= pushout_d;
      firstout_q <= firstout_d;
      dout_q     <= dout_d;
    end
  end

  assign pushout  = pushout_q;
  assign firstout = firstout_q;
  assign dout     = dout_q;

endmodule

// File: tb/tb_perm_feed.sv
// Self-checking bench for perm_feed: a byte-level pad10*1 model fills a scoreboard
// of expected lanes that a negedge monitor compares against transferred output lanes.
module tb_perm_feed;
  import keccak_pkg::*;

  localparam int RATE = 17;

  typedef struct packed {
    logic        first;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, pushin, lastin, stopout, stopin, pushout, firstout;
  logic [3:0]  nbytes;
  logic [63:0] din, dout;

  exp_t        exp_q[$];
  logic [63:0] msg[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          lane_no    = 0;
  bit          mon_en     = 1'b0;
  bit          rand_stall = 1'b0;

  perm_feed #(.RATE(RATE)) dut (
    .clk      (clk),
    .rst      (rst),
    .pushin   (pushin),
    .stopin   (stopin),
    .lastin   (lastin),
    .nbytes   (nbytes),
    .din      (din),
    .pushout  (pushout),
    .stopout  (stopout),
    .firstout (firstout),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference model: pad the message bytes to whole rate blocks, then frame them.
  task automatic build_expect(input int nb);
    logic [7:0]  mb[$];
    logic [63:0] w;
    exp_t        e;
    int          n, blk, nf;
    n   = (nb > 8) ? 8 : nb;
    blk = 8 * RATE;
    for (int i = 0; i < msg.size(); i++) begin
      int cnt;
      cnt = (i == msg.size() - 1) ? n : 8;
      w   = msg[i];
      for (int b = 0; b < cnt; b++) mb.push_back(w[8*b +: 8]);
    end
    mb.push_back(8'h06);
    while ((mb.size() % blk) != 0) mb.push_back(8'h00);
    mb[mb.size()-1] = mb[mb.size()-1] | 8'h80;
    nf = mb.size() / blk;
    for (int f = 0; f < nf; f++) begin
      for (int l = 0; l < LANES; l++) begin
        w = '0;
        if (l < RATE) begin
          for (int b = 0; b < 8; b++) w[8*b +: 8] = mb[f*blk + 8*l + b];
        end
        e.first = (l == 0);
        e.data  = w;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_msg(input int nb, input bit model, input bit do_last);
    bit accepted;
    if (model) build_expect(nb);
    for (int w = 0; w < msg.size(); w++) begin
      pushin   = 1'b1;
      din      = msg[w];
      lastin   = do_last && (w == msg.size() - 1);
      nbytes   = 4'(nb);
      accepted = 1'b0;
      for (int c = 0; c < 300 && !accepted; c++) begin
        @(negedge clk);
        if (!stopin) accepted = 1'b1;
        @(posedge clk);
        #1;
      end
      if (!accepted) check($sformatf("word%0d_accept_timeout", w), 64'(stopin), 64'd0);
    end
    pushin = 1'b0;
    lastin = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check({tag, "_lanes_left"}, 64'(exp_q.size()), 64'd0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Stall generator for the permutation-side backpressure.
  initial begin
    stopout = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stopout = rand_stall ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: a lane transfers on the next posedge when pushout & !stopout here.
  initial begin
    exp_t        e;
    bit          prev_stall;
    logic        prev_first;
    logic [63:0] prev_dout;
    prev_stall = 1'b0;
    prev_first = 1'b0;
    prev_dout  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("held_pushout", 64'(pushout), 64'd1);
          check("held_dout", dout, prev_dout);
          check("held_firstout", 64'(firstout), 64'(prev_first));
        end
        if (pushout && stopout) check("stopin_on_stall", 64'(stopin), 64'd1);
        prev_stall = pushout && stopout;
        prev_dout  = dout;
        prev_first = firstout;
        if (pushout && !stopout && mon_en) begin
          if (exp_q.size() == 0) begin
            check($sformatf("extra_lane%0d", lane_no), 64'(pushout), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("lane%0d_dout", lane_no), dout, e.data);
            check($sformatf("lane%0d_firstout", lane_no), 64'(firstout), 64'(e.first));
          end
          lane_no++;
        end
      end
    end
  end

  initial begin
    int base;
    rst    = 1'b1;
    pushin = 1'b0;
    lastin = 1'b0;
    nbytes = 4'd0;
    din    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pushout", 64'(pushout), 64'd0);
    check("reset_firstout", 64'(firstout), 64'd0);
    check("reset_dout", dout, 64'd0);
    check("reset_stopin", 64'(stopin), 64'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Empty message: the single word's payload must be masked away entirely.
    msg = '{64'hDEAD_BEEF_CAFE_F00D};
    send_msg(0, 1'b1, 1'b1);
    wait_drain("empty");

    msg = '{64'h1122_3344_5566_7788};
    send_msg(3, 1'b1, 1'b1);
    wait_drain("three_bytes");

    // Full final word landing on the last rate lane forces an extra pad frame.
    msg.delete();
    for (int i = 0; i < RATE; i++) msg.push_back({$urandom(), $urandom()});
    send_msg(8, 1'b1, 1'b1);
    wait_drain("rate_full");

    msg[RATE-1] = 64'h0000_0000_0000_AAAA;
    send_msg(2, 1'b1, 1'b1);
    wait_drain("rate_end_partial");

    msg[RATE-1] = 64'h0123_4567_89AB_CDEF;
    send_msg(7, 1'b1, 1'b1);
    wait_drain("rate_end_seven");

    // Oversized nbytes behaves as a full word; the pad lands in a separate lane.
    msg.delete();
    for (int i = 0; i < 5; i++) msg.push_back({$urandom(), $urandom()});
    send_msg(12, 1'b1, 1'b1);
    wait_drain("nbytes_over");

    rand_stall = 1'b1;
    msg.delete();
    for (int i = 0; i < 2*RATE + 5; i++) msg.push_back({$urandom(), $urandom()});
    send_msg(5, 1'b1, 1'b1);
    wait_drain("random_stall");
    rand_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Abandon a frame with lane 9 in the output register, then restart cleanly.
    mon_en = 1'b0;
    msg.delete();
    for (int i = 0; i < 10; i++) msg.push_back({$urandom(), $urandom()});
    send_msg(8, 1'b0, 1'b0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midreset_pushout", 64'(pushout), 64'd0);
    end
    check("midreset_firstout", 64'(firstout), 64'd0);
    check("midreset_dout", dout, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    base = lane_no;
    msg = '{64'h0000_0000_00C0_FFEE};
    send_msg(4, 1'b1, 1'b1);
    wait_drain("after_reset");
    check("after_reset_lane_count", 64'(lane_no - base), 64'd25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
